// File: rtl/ascon_word_fifo_if.sv
// Handshake/status bundle for ascon_word_fifo.
// Signals:
//   clear_i, push_i, d_i, pop_i   - requests driven by the producer/consumer side
//   q_o, empty_o, full_o, count_o - head word and occupancy status from the FIFO
//   overflow_o, underflow_o       - sticky error flags from the FIFO
// Modports:
//   master - the side that pushes/pops (datapath or bench)
//   slave  - the FIFO itself
interface ascon_word_fifo_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             clear_i;
  logic             push_i;
  logic [WIDTH-1:0] d_i;
  logic             pop_i;
  logic [WIDTH-1:0] q_o;
  logic             empty_o;
  logic             full_o;
  logic [CW-1:0]    count_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output clear_i, push_i, d_i, pop_i,
    input  q_o, empty_o, full_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  clear_i, push_i, d_i, pop_i,
    output q_o, empty_o, full_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/ascon_word_fifo.sv
// Synchronous word FIFO buffering ASCON cipher/tag words until the output side consumes them.
// Ports:
//   clock_i - rising-edge clock
//   reset_i - synchronous active-high reset; clears pointers, count, flags and storage
//   fifo_io - ascon_word_fifo_if slave modport: clear/push/pop requests, head word q_o,
//             empty/full/count status and sticky overflow/underflow flags
// The head word is a combinational read of the registered storage, forced to 0 when empty.
module ascon_word_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input logic               clock_i,
  input logic               reset_i,
  ascon_word_fifo_if.slave  fifo_io
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic empty, full;
  logic push_acc, pop_acc;
  logic wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_acc = fifo_io.push_i & (~full | fifo_io.pop_i);
  assign pop_acc  = fifo_io.pop_i & ~empty;
  // Flush wins over a concurrent push, so storage is left untouched.
  assign wr_en    = push_acc & ~fifo_io.clear_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (fifo_io.clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers roll over naturally.
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (fifo_io.push_i && !push_acc) overflow_d  = 1'b1;
      if (fifo_io.pop_i && !pop_acc)   underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= fifo_io.d_i;
      end
    end
  end

  assign fifo_io.q_o         = empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_io.empty_o     = empty;
  assign fifo_io.full_o      = full;
  assign fifo_io.count_o     = count_q;
  assign fifo_io.overflow_o  = overflow_q;
  assign fifo_io.underflow_o = underflow_q;
endmodule
